mac_table_ctrl: RTL

MAC_TABLE_CTRL -- requirements
Module: mac_table_ctrl

---
 rtl/mac_table_pkg.sv | 30 +++
 rtl/mac_hash.sv | 29 ++
 rtl/mac_table_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_table_pkg.sv
// mac_table_pkg: definitions shared by the MAC learning-table controller.
//   - FSM state encoding (plain localparam constants, kept legacy-friendly)
//   - Field offsets of a table entry {valid, mac[47:0], port}, valid on top
//   - entry_width(): width of one table entry for a given port width
package mac_table_pkg;

  localparam int MAC_WIDTH = 48;

  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_CMP   = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // The port number sits in the low bits of an entry.
  localparam int PORT_LSB = 0;

  function automatic int mac_lsb(input int port_width);
    return PORT_LSB + port_width;
  endfunction

  function automatic int valid_bit(input int port_width);
    return PORT_LSB + port_width + MAC_WIDTH;
  endfunction

  function automatic int entry_width(input int port_width);
    return 1 + MAC_WIDTH + port_width;
  endfunction

endpackage

// File: rtl/mac_hash.sv
// mac_hash: combinational table index for a 48-bit MAC address.
// The MAC is cut into ADDR_WIDTH-bit chunks starting at bit 0 (the top
// chunk zero-padded) and all chunks are XORed together.
// Ports:
//   mac_i   in   48          MAC address
//   hash_o  out  ADDR_WIDTH  table index
module mac_hash
  import mac_table_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic [MAC_WIDTH-1:0]  mac_i,
  output logic [ADDR_WIDTH-1:0] hash_o
);

  localparam int NCHUNK = (MAC_WIDTH + ADDR_WIDTH - 1) / ADDR_WIDTH;

  logic [NCHUNK*ADDR_WIDTH-1:0] padded;

  always_comb begin
    padded                  = '0;
    padded[MAC_WIDTH-1:0]   = mac_i;
    hash_o                  = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      hash_o = hash_o ^ padded[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

endmodule

// File: rtl/mac_table_ctrl.sv
// mac_table_ctrl: lookup/learn controller for a MAC address table held in
// an external single-port RAM with one cycle of registered read latency.
// A request accepted in cycle N reads the hashed slot in N+1, compares in
// N+2 and answers in N+3, optionally writing the learned entry back in the
// same cycle. After reset, or on flush, every slot is written to zero.
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   req_valid/req_ready  request handshake; ready only in IDLE
//   req_mac/req_port     MAC to look up, source port to learn
//   req_learn            1 = lookup + learn, 0 = lookup only
//   resp_valid           one-cycle response strobe
//   resp_hit/resp_port   lookup result (port is 0 on a miss)
//   flush                one-cycle request to clear the table
//   busy                 high while clearing
//   ram_we/ram_addr/ram_din/ram_dout  external RAM port
module mac_table_ctrl
  import mac_table_pkg::*;
#(
  parameter  int ADDR_WIDTH  = 10,
  parameter  int PORT_WIDTH  = 4,
  localparam int ENTRY_WIDTH = entry_width(PORT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [MAC_WIDTH-1:0]   req_mac,
  input  logic [PORT_WIDTH-1:0]  req_port,
  input  logic                   req_learn,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [PORT_WIDTH-1:0]  resp_port,
  input  logic                   flush,
  output logic                   busy,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [ENTRY_WIDTH-1:0] ram_din,
  input  logic [ENTRY_WIDTH-1:0] ram_dout
);

  logic [2:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  clr_addr_q, clr_addr_d;
  logic [MAC_WIDTH-1:0]   mac_q, mac_d;
  logic [PORT_WIDTH-1:0]  port_q, port_d;
  logic                   learn_q, learn_d;
  logic                   flush_pend_q, flush_pend_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_hit_q, resp_hit_d;
  logic [PORT_WIDTH-1:0]  resp_port_q, resp_port_d;
  logic                   busy_q, busy_d;
  logic                   ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
  logic [ENTRY_WIDTH-1:0] ram_din_q, ram_din_d;

  logic [ADDR_WIDTH-1:0]  hash;
  logic                   stored_valid;
  logic [MAC_WIDTH-1:0]   stored_mac;
  logic [PORT_WIDTH-1:0]  stored_port;
  logic                   hit;

  // Hash the live request MAC so the read address is registered on the
  // handshake edge and presented to the RAM in the READ cycle.
  mac_hash #(.ADDR_WIDTH(ADDR_WIDTH)) u_hash (
    .mac_i  (req_mac),
    .hash_o (hash)
  );

  assign stored_valid = ram_dout[valid_bit(PORT_WIDTH)];
  assign stored_mac   = ram_dout[mac_lsb(PORT_WIDTH) +: MAC_WIDTH];
  assign stored_port  = ram_dout[PORT_LSB +: PORT_WIDTH];
  assign hit          = stored_valid && (stored_mac == mac_q);

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_port  = resp_port_q;
  assign busy       = busy_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;

  always_comb begin
    // NOTE: every next-state value starts from its held value (strobes from
    // zero) before the case, so no path leaves one unassigned and no latch
    // is inferred.
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    mac_d        = mac_q;
    port_d       = port_q;
    learn_d      = learn_q;
    flush_pend_d = flush_pend_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_port_d  = resp_port_q;
    busy_d       = busy_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;

    case (state_q)
      ST_CLEAR: begin
        // Flush is ignored here; a running clear never restarts.
        flush_pend_d = 1'b0;
        busy_d       = 1'b1;
        ram_din_d    = '0;
        // Outputs are registered, so the write to the last address is on the
        // bus one cycle after it was scheduled; leave only once it is out.
        if (ram_we_q && (ram_addr_q == '1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = clr_addr_q;
          if (clr_addr_q != '1) begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
          end
        end
      end

      ST_IDLE: begin
        // A request offered together with flush is still accepted (ready is
        // high), so the flush is deferred until that request has answered.
        if (req_valid) begin
          mac_d        = req_mac;
          port_d       = req_port;
          learn_d      = req_learn;
          ram_addr_d   = hash;
          flush_pend_d = flush;
          state_d      = ST_READ;
        end else if (flush) begin
          state_d      = ST_CLEAR;
          clr_addr_d   = '0;
          ram_addr_d   = '0;
          ram_din_d    = '0;
          busy_d       = 1'b1;
          flush_pend_d = 1'b0;
        end
      end

      ST_READ: begin
        flush_pend_d = flush_pend_q | flush;
        state_d      = ST_CMP;
      end

      ST_CMP: begin
        flush_pend_d = flush_pend_q | flush;
        resp_valid_d = 1'b1;
        resp_hit_d   = hit;
        resp_port_d  = hit ? stored_port : '0;
        // Learn on a miss (including a colliding MAC, which is evicted) or
        // when the station has moved to another port.
        if (learn_q && (!hit || (stored_port != port_q))) begin
          ram_we_d  = 1'b1;
          ram_din_d = {1'b1, mac_q, port_q};
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (flush_pend_q || flush) begin
          state_d      = ST_CLEAR;
          clr_addr_d   = '0;
          ram_addr_d   = '0;
          ram_din_d    = '0;
          busy_d       = 1'b1;
          flush_pend_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d      = ST_CLEAR;
        clr_addr_d   = '0;
        ram_addr_d   = '0;
        ram_din_d    = '0;
        busy_d       = 1'b1;
        flush_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      mac_q        <= '0;
      port_q       <= '0;
      learn_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_port_q  <= '0;
      busy_q       <= 1'b1;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      mac_q        <= mac_d;
      port_q       <= port_d;
      learn_q      <= learn_d;
      flush_pend_q <= flush_pend_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_port_q  <= resp_port_d;
      busy_q       <= busy_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
    end
  end

endmodule
